// File: rtl/multi_channel_reload_timer_if.sv
// Bus bundle for multi_channel_reload_timer: control inputs and per-channel status.
// The irq_clear/irq pair exists only when TIMER_IRQ_STICKY_EN is defined.
interface multi_channel_reload_timer_if #(
   parameter int WIDTH      = 16,
   parameter int NUM_CH     = 4,
   parameter int PRESCALE_W = 8
);
   logic [PRESCALE_W-1:0]   prescale;
   logic [NUM_CH*WIDTH-1:0] load_value;
   logic [NUM_CH-1:0]       mode;
   logic [NUM_CH-1:0]       start;
   logic [NUM_CH-1:0]       stop;
   logic [NUM_CH*WIDTH-1:0] count;
   logic [NUM_CH-1:0]       running;
   logic [NUM_CH-1:0]       done;
`ifdef TIMER_IRQ_STICKY_EN
   logic [NUM_CH-1:0]       irq_clear;
   logic                    irq;

   modport master (
      output prescale, load_value, mode, start, stop, irq_clear,
      input  count, running, done, irq
   );
   modport slave (
      input  prescale, load_value, mode, start, stop, irq_clear,
      output count, running, done, irq
   );
`else
   modport master (
      output prescale, load_value, mode, start, stop,
      input  count, running, done
   );
   modport slave (
      input  prescale, load_value, mode, start, stop,
      output count, running, done
   );
`endif
endinterface

// File: rtl/multi_channel_reload_timer.sv
// NUM_CH down-counting timers (periodic or one-shot) clocked by one shared prescaler tick.
// Optional sticky interrupt aggregation is compiled in with TIMER_IRQ_STICKY_EN.
module multi_channel_reload_timer #(
   parameter int WIDTH      = 16,
   parameter int NUM_CH     = 4,
   parameter int PRESCALE_W = 8
) (
   input logic                        clk,
   input logic                        rst,
   multi_channel_reload_timer_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_e;

   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic                  tick;

   ch_state_e             state_q [NUM_CH];
   ch_state_e             state_d [NUM_CH];
   logic [WIDTH-1:0]      count_q [NUM_CH];
   logic [WIDTH-1:0]      count_d [NUM_CH];
   logic [WIDTH-1:0]      ld_val  [NUM_CH];
   logic [NUM_CH-1:0]     done_q, done_d;

   // Free-running divider; lowering prescale below pre_cnt lets it wrap before the next tick.
   always_comb begin
      tick      = (pre_cnt_q == bus.prescale);
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
   end

   // NOTE: every *_d gets its hold value first, so no path through the branches leaves a latch.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         count_d[i] = count_q[i];
         done_d[i]  = 1'b0;
         if (bus.stop[i]) begin
            state_d[i] = IDLE;
         end else begin
            if (state_q[i] == RUN && tick) begin
               if (count_q[i] == WIDTH'(1)) begin
                  done_d[i] = 1'b1;
                  if (bus.mode[i] && ld_val[i] != '0) begin
                     count_d[i] = ld_val[i];
                  end else begin
                     count_d[i] = '0;
                     state_d[i] = IDLE;
                  end
               end else begin
                  count_d[i] = count_q[i] - WIDTH'(1);
               end
            end
            // A valid start overrides the tick result but keeps any expiry pulse.
            if (bus.start[i] && ld_val[i] != '0) begin
               count_d[i] = ld_val[i];
               state_d[i] = RUN;
            end
         end
      end
   end

   // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_q <= '0;
         done_q    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= IDLE;
            count_q[i] <= '0;
         end
      end else begin
         pre_cnt_q <= pre_cnt_d;
         done_q    <= done_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            count_q[i] <= count_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign ld_val[g]                       = bus.load_value[g*WIDTH +: WIDTH];
      assign bus.count[g*WIDTH +: WIDTH]     = count_q[g];
      assign bus.running[g]                  = (state_q[g] == RUN);
   end
   assign bus.done = done_q;

`ifdef TIMER_IRQ_STICKY_EN
   logic [NUM_CH-1:0] irq_status_q, irq_status_d;
   logic              irq_q, irq_d;

   // A done pulse beats a simultaneous clear so an expiry is never lost.
   always_comb begin
      irq_status_d = done_q | (irq_status_q & ~bus.irq_clear);
      irq_d        = |irq_status_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_status_q <= '0;
         irq_q        <= 1'b0;
      end else begin
         irq_status_q <= irq_status_d;
         irq_q        <= irq_d;
      end
   end

   assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_multi_channel_reload_timer.sv
// Randomised and directed bench for multi_channel_reload_timer with a cycle-level reference model.
// Covers TIMER_IRQ_STICKY_EN when the macro is defined for the build.
module tb_multi_channel_reload_timer;
   localparam int WIDTH      = 16;
   localparam int NUM_CH     = 4;
   localparam int PRESCALE_W = 8;
   localparam int PRE_MOD    = 1 << PRESCALE_W;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   multi_channel_reload_timer_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .PRESCALE_W(PRESCALE_W)) bus ();

   multi_channel_reload_timer #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .PRESCALE_W(PRESCALE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec rules evaluated once per edge with plain integers.
   int   m_pre;
   int   m_cnt  [NUM_CH];
   bit   m_run  [NUM_CH];
   bit   m_done [NUM_CH];
   bit   m_stat [NUM_CH];
   bit   m_irq;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pre = 0;
         m_irq = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 0; m_stat[i] = 0;
         end
      end else begin
         bit tk;
         tk    = (m_pre == int'(bus.prescale));
         m_pre = tk ? 0 : (m_pre + 1) % PRE_MOD;
         m_irq = 0;
         for (int i = 0; i < NUM_CH; i++) m_irq = m_irq | m_stat[i];
`ifdef TIMER_IRQ_STICKY_EN
         for (int i = 0; i < NUM_CH; i++) m_stat[i] = m_done[i] | (m_stat[i] & !bus.irq_clear[i]);
`endif
         for (int i = 0; i < NUM_CH; i++) begin
            int ld;
            ld        = int'(bus.load_value[i*WIDTH +: WIDTH]);
            m_done[i] = 0;
            if (bus.stop[i]) begin
               m_run[i] = 0;
            end else begin
               if (m_run[i] && tk && m_cnt[i] == 1) begin
                  m_done[i] = 1;
                  if (bus.mode[i] && ld != 0) m_cnt[i] = ld;
                  else begin m_cnt[i] = 0; m_run[i] = 0; end
               end else if (m_run[i] && tk) begin
                  m_cnt[i] = m_cnt[i] - 1;
               end
               if (bus.start[i] && ld != 0) begin
                  m_cnt[i] = ld; m_run[i] = 1;
               end
            end
         end
      end
   end

   // Compare process: every cycle, just after the active edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         check($sformatf("model_count[%0d]", i), 64'(bus.count[i*WIDTH +: WIDTH]), 64'(m_cnt[i]));
         check($sformatf("model_running[%0d]", i), 64'(bus.running[i]), 64'(m_run[i]));
         check($sformatf("model_done[%0d]", i), 64'(bus.done[i]), 64'(m_done[i]));
      end
`ifdef TIMER_IRQ_STICKY_EN
      check("model_irq", 64'(bus.irq), 64'(m_irq));
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load(input int ch, input int v);
      bus.load_value[ch*WIDTH +: WIDTH] = WIDTH'(v);
   endtask

   function automatic int cnt_of(input int ch);
      return int'(bus.count[ch*WIDTH +: WIDTH]);
   endfunction

   task automatic reset_pulse();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int hit;
      int extra;
      rst            = 1'b1;
      bus.prescale   = '0;
      bus.load_value = '0;
      bus.mode       = '0;
      bus.start      = '0;
      bus.stop       = '0;
`ifdef TIMER_IRQ_STICKY_EN
      bus.irq_clear  = '0;
`endif
      step();
      step();
      check("reset_count", 64'(bus.count), 64'(0));
      check("reset_running", 64'(bus.running), 64'(0));
      check("reset_done", 64'(bus.done), 64'(0));
      rst = 1'b0;

      // Periodic, prescale 0, load 4
      set_load(0, 4); bus.mode[0] = 1'b1; bus.start[0] = 1'b1;
      step();
      bus.start[0] = 1'b0;
      check("per_start_count", 64'(cnt_of(0)), 64'(4));
      check("per_start_running", 64'(bus.running[0]), 64'(1));
      step(); step(); step();
      check("per_count_one", 64'(cnt_of(0)), 64'(1));
      check("per_no_early_done", 64'(bus.done[0]), 64'(0));
      step();
      check("per_done_e4", 64'(bus.done[0]), 64'(1));
      check("per_reload_e4", 64'(cnt_of(0)), 64'(4));
      repeat (4) step();
      check("per_done_e8", 64'(bus.done[0]), 64'(1));
      repeat (4) step();
      check("per_done_e12", 64'(bus.done[0]), 64'(1));
      check("per_still_running", 64'(bus.running[0]), 64'(1));
      bus.stop[0] = 1'b1;
      step();
      bus.stop[0] = 1'b0;
      check("per_stopped", 64'(bus.running[0]), 64'(0));

      // One-shot with prescale 2, load 3
      bus.prescale = 8'd2; set_load(1, 3); bus.mode[1] = 1'b0; bus.start[1] = 1'b1;
      step();
      bus.start[1] = 1'b0;
      hit = 0;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (bus.done[1]) begin hit = k; break; end
      end
      check("oneshot_latency", 64'(hit), 64'(8));
      check("oneshot_running", 64'(bus.running[1]), 64'(0));
      check("oneshot_count", 64'(cnt_of(1)), 64'(0));
      extra = 0;
      repeat (12) begin step(); extra += int'(bus.done[1]); end
      check("oneshot_no_more_done", 64'(extra), 64'(0));
      bus.prescale = '0;
      reset_pulse();

      // Stop beats start
      set_load(2, 5); bus.mode[2] = 1'b1; bus.start[2] = 1'b1;
      step();
      check("ss_loaded", 64'(cnt_of(2)), 64'(5));
      bus.stop[2] = 1'b1;
      step();
      bus.stop[2] = 1'b0;
      check("ss_stop_running", 64'(bus.running[2]), 64'(0));
      check("ss_stop_hold", 64'(cnt_of(2)), 64'(5));
      set_load(2, 7);
      step();
      bus.start[2] = 1'b0;
      check("ss_restart_count", 64'(cnt_of(2)), 64'(7));
      check("ss_restart_running", 64'(bus.running[2]), 64'(1));
      bus.stop[2] = 1'b1;
      step();
      bus.stop[2] = 1'b0;

      // Zero load
      set_load(3, 0); bus.mode[3] = 1'b1; bus.start[3] = 1'b1;
      step();
      bus.start[3] = 1'b0;
      check("zero_start_ignored", 64'(bus.running[3]), 64'(0));
      set_load(3, 2); bus.start[3] = 1'b1;
      step();
      bus.start[3] = 1'b0; set_load(3, 0);
      step();
      check("zero_reload_count1", 64'(cnt_of(3)), 64'(1));
      step();
      check("zero_reload_done", 64'(bus.done[3]), 64'(1));
      check("zero_reload_stopped", 64'(bus.running[3]), 64'(0));
      check("zero_reload_count0", 64'(cnt_of(3)), 64'(0));
      step();
      check("zero_done_once", 64'(bus.done[3]), 64'(0));
      reset_pulse();

      // Restart on expiry, then asynchronous reset
      set_load(0, 3); bus.mode[0] = 1'b1; bus.start[0] = 1'b1;
      step();
      bus.start[0] = 1'b0;
      step(); step();
      check("rexp_count1", 64'(cnt_of(0)), 64'(1));
      set_load(0, 10); bus.start[0] = 1'b1;
      step();
      bus.start[0] = 1'b0;
      check("rexp_done", 64'(bus.done[0]), 64'(1));
      check("rexp_count10", 64'(cnt_of(0)), 64'(10));
      #2 rst = 1'b1;
      #1;
      check("async_rst_count", 64'(bus.count), 64'(0));
      check("async_rst_running", 64'(bus.running), 64'(0));
      check("async_rst_done", 64'(bus.done), 64'(0));
      step();
      rst = 1'b0;

`ifdef TIMER_IRQ_STICKY_EN
      set_load(0, 1); set_load(1, 1); bus.mode[1:0] = 2'b00; bus.start[1:0] = 2'b11;
      step();
      bus.start[1:0] = 2'b00;
      step(); step(); step();
      check("irq_set", 64'(bus.irq), 64'(1));
      step();
      check("irq_sticky", 64'(bus.irq), 64'(1));
      bus.irq_clear[0] = 1'b1;
      step();
      bus.irq_clear[0] = 1'b0;
      step();
      check("irq_one_left", 64'(bus.irq), 64'(1));
      bus.irq_clear[1] = 1'b1;
      step();
      bus.irq_clear[1] = 1'b0;
      step();
      check("irq_all_clear", 64'(bus.irq), 64'(0));
      bus.start[0] = 1'b1;
      step();
      bus.start[0] = 1'b0;
      step();
      bus.irq_clear[0] = 1'b1;
      step();
      bus.irq_clear[0] = 1'b0;
      step();
      check("irq_set_beats_clear", 64'(bus.irq), 64'(1));
      reset_pulse();
`endif

      // Random phase
      bus.mode = '0; bus.load_value = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 199) == 0) bus.prescale = PRESCALE_W'($urandom_range(0, 3));
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(0, 9) == 0) set_load(i, $urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) bus.mode[i] = ~bus.mode[i];
            bus.start[i] = ($urandom_range(0, 11) == 0);
            bus.stop[i]  = ($urandom_range(0, 29) == 0);
`ifdef TIMER_IRQ_STICKY_EN
            bus.irq_clear[i] = ($urandom_range(0, 7) == 0);
`endif
         end
         if ($urandom_range(0, 499) == 0) begin
            #3 rst = 1'b1;
            step();
            rst = 1'b0;
         end else begin
            step();
         end
      end
      bus.start = '0;
      bus.stop  = '0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_channel_reload_timer.md
Name: multi_channel_reload_timer

Overview:
- NUM_CH independent down-counting timers sharing one programmable prescaler.
- Each channel runs in periodic (auto-reload) or one-shot mode, with explicit start/stop control and a one-cycle done pulse on expiry.
- Replaces single-channel auto-reload timers where several timebases are needed (tick generators, timeouts, PWM period sources).

Parameters:
- WIDTH, 16, counter and load width per channel
- NUM_CH, 4, number of channels (>=1)
- PRESCALE_W, 8, width of shared prescaler divisor

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- prescale  in  PRESCALE_W  tick divisor; tick every prescale+1 clk cycles
- load_value  in  NUM_CH*WIDTH  per-channel period; channel i at [i*WIDTH +: WIDTH]
- mode  in  NUM_CH  per channel: 1 = periodic, 0 = one-shot
- start  in  NUM_CH  per-channel start/restart strobe
- stop  in  NUM_CH  per-channel stop strobe
- count  out  NUM_CH*WIDTH  current counter value per channel
- running  out  NUM_CH  channel active
- done  out  NUM_CH  one-cycle expiry pulse, registered

Behaviour:
Reset (async, rst=1):
- prescaler counter = 0.
- All count = 0, running = 0, done = 0.
- Reset mid-count aborts every channel immediately; no done is generated.

Prescaler:
- Free-running counter pre_cnt. tick = (pre_cnt == prescale).
- On tick, pre_cnt <= 0; otherwise pre_cnt <= pre_cnt + 1.
- prescale = 0 gives tick every cycle.
- If prescale is lowered below pre_cnt, pre_cnt wraps through 2^PRESCALE_W before the next tick; this is accepted behaviour.
- Prescaler is shared and never reset by start.

Per-channel states: IDLE (running=0) and RUN (running=1). Priority per edge, highest first:
1. stop[i]=1: running <= 0, count holds. stop wins over a simultaneous start. No done, even if expiry coincides.
2. start[i]=1:
   - load_value[i] != 0: count <= load_value[i], running <= 1. Applies in IDLE or RUN (restart); pending prescaler phase is not realigned.
   - load_value[i] = 0: start is ignored and state is unchanged.
3. RUN && tick && count==1 (expiry): done[i] <= 1 for exactly one cycle.
   - mode[i]=1: count <= load_value[i] (sampled at this edge). If that value is 0, running <= 0 and count <= 0.
   - mode[i]=0: count <= 0, running <= 0.
4. RUN && tick && count>1: count <= count - 1.
5. Otherwise hold.

Timing and arithmetic:
- done is 0 on every cycle without an expiry.
- If start coincides with expiry, start wins: count reloads and done still pulses.
- Period = load_value * (prescale+1) clk cycles. With prescale=0, the first done occurs exactly load_value edges after the start edge.
- mode and load_value changes in RUN take effect at the next reload only.
- Channels are fully independent. No arithmetic overflow is possible because count never decrements below 1.

Optional Feature:
Macro TIMER_IRQ_STICKY_EN.
- Defined: adds ports irq_clear (in, NUM_CH) and irq (out, 1), plus an internal irq_status[NUM_CH] register.
  - irq_status[i] sets on done[i], clears on irq_clear[i]; set wins if both occur in the same cycle.
  - irq = OR of irq_status, registered; reset value 0.
- Undefined: these ports and logic are absent, and done is the only expiry indication.

Test Plan:
- Periodic: prescale=0, ch0 load=4, mode=1, start at edge E0 -> count 4,3,2,1; done[0] high after E4, E8, E12; running stays 1.
- One-shot with prescale: prescale=2, ch1 load=3, mode=0, start -> single done after 9 ticks-worth of cycles (±2 for prescaler phase); then running=0, count=0, no further done.
- Stop/start priority: ch2 running with count=5, assert start and stop together -> running=0, count stays 5. Next cycle start alone with load=7 -> count=7, running=1.
- Zero load: load=0, start -> running stays 0, done never asserts. Periodic channel reloading with load changed to 0 -> done pulses once, then running=0, count=0.
- Restart on expiry plus async reset: ch0 at count=1 with start and load=10 on the expiry edge -> done=1, count=10. Assert rst mid-count -> all outputs 0 immediately, without waiting for clk.
- With TIMER_IRQ_STICKY_EN: two channels expire -> irq=1 and stays high. Clear one -> irq still 1. Clear other -> irq=0. done coincident with clear -> status remains set.
